// File: rtl/ram_block_mover_if.sv
// rtl/ram_block_mover_if.sv - command and single-port RAM bus bundle for ram_block_mover
interface ram_block_mover_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16
);
   logic                  start;
   logic                  fill;
   logic [ADDR_WIDTH-1:0] src;
   logic [ADDR_WIDTH-1:0] dst;
   logic [ADDR_WIDTH-1:0] len;
   logic [DATA_WIDTH-1:0] fill_value;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_out;
   logic                  mem_load;
   logic [DATA_WIDTH-1:0] mem_in;

   modport master (
      input  start, fill, src, dst, len, fill_value, mem_in,
      output busy, done, mem_address, mem_out, mem_load
   );

   modport slave (
      output start, fill, src, dst, len, fill_value, mem_in,
      input  busy, done, mem_address, mem_out, mem_load
   );
endinterface

// File: rtl/ram_block_mover.sv
// rtl/ram_block_mover.sv - RAM-to-RAM block copy / constant fill bus initiator
module ram_block_mover #(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   ram_block_mover_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

   localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   logic                  fill_q, fill_d;
   logic [DATA_WIDTH-1:0] fv_q, fv_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [1:0]            wait_q, wait_d;
   logic [ADDR_WIDTH-1:0] idx_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         fill_q  <= 1'b0;
         fv_q    <= '0;
         data_q  <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         fill_q  <= fill_d;
         fv_q    <= fv_d;
         data_q  <= data_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      src_d           = src_q;
      dst_d           = dst_q;
      len_d           = len_q;
      fill_d          = fill_q;
      fv_d            = fv_q;
      data_d          = data_q;
      wait_d          = wait_q;
      idx_next        = idx_q + ADDR_WIDTH'(1);
      bus.busy        = 1'b0;
      bus.done        = 1'b0;
      bus.mem_address = '0;
      bus.mem_out     = '0;
      bus.mem_load    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               src_d  = bus.src;
               dst_d  = bus.dst;
               len_d  = bus.len;
               fill_d = bus.fill;
               fv_d   = bus.fill_value;
               idx_d  = '0;
               if (bus.len == '0)  state_d = S_DONE;
               else if (bus.fill)  state_d = S_WRITE;
               else                state_d = S_READ;
            end
         end
         S_READ: begin
            bus.busy        = 1'b1;
            bus.mem_address = src_q + idx_q;
            wait_d          = WAIT_INIT;
            state_d         = S_WAIT;
         end
         S_WAIT: begin
            // Address is held for the whole latency window so any RAM pipeline depth sees it.
            bus.busy        = 1'b1;
            bus.mem_address = src_q + idx_q;
            if (wait_q == 2'd0) begin
               data_d  = bus.mem_in;
               state_d = S_WRITE;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         S_WRITE: begin
            bus.busy        = 1'b1;
            bus.mem_address = dst_q + idx_q;
            bus.mem_load    = 1'b1;
            bus.mem_out     = fill_q ? fv_q : data_q;
            idx_d           = idx_next;
            if (idx_next == len_q) state_d = S_DONE;
            else if (fill_q)       state_d = S_WRITE;
            else                   state_d = S_READ;
         end
         S_DONE: begin
            bus.done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_ram_block_mover.sv
// tb/tb_ram_block_mover.sv - lockstep bench for READ_LATENCY 1 and 3 movers against a behavioural model
module tb_ram_block_mover;
   localparam int AW = 12;
   localparam int DW = 16;
   localparam int N  = 1 << AW;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic          st = 1'b0, fl = 1'b0;
   logic [AW-1:0] sr = '0, ds = '0, ln = '0;
   logic [DW-1:0] fv = '0;
   logic          pl_we = 1'b0;
   logic [AW-1:0] pl_a = '0;
   logic [DW-1:0] pl_d = '0;
   logic          chk_en = 1'b0;
   int            n_chk = 0, n_fail = 0;

   logic [DW-1:0] ram  [2][N];
   logic [DW-1:0] gold [2][N];
   logic [AW-1:0] a1;
   logic [AW-1:0] a3 [3];

   ram_block_mover_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
   ram_block_mover_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

   assign bus1.start = st;  assign bus1.fill = fl;  assign bus1.src = sr;
   assign bus1.dst = ds;    assign bus1.len = ln;   assign bus1.fill_value = fv;
   assign bus3.start = st;  assign bus3.fill = fl;  assign bus3.src = sr;
   assign bus3.dst = ds;    assign bus3.len = ln;   assign bus3.fill_value = fv;
   assign bus1.mem_in = ram[0][a1];
   assign bus3.mem_in = ram[1][a3[2]];

   ram_block_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1));
   ram_block_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .bus(bus3));

   logic          dbusy [2], ddone [2], dload [2];
   logic [AW-1:0] daddr [2];
   logic [DW-1:0] dout  [2];
   always_comb begin
      dbusy[0] = bus1.busy;  ddone[0] = bus1.done;  dload[0] = bus1.mem_load;
      daddr[0] = bus1.mem_address;  dout[0] = bus1.mem_out;
      dbusy[1] = bus3.busy;  ddone[1] = bus3.done;  dload[1] = bus3.mem_load;
      daddr[1] = bus3.mem_address;  dout[1] = bus3.mem_out;
   end

   // Model: operation described by cycle index k after accept; word = (k-1)/P, phase = (k-1)%P.
   logic          act [2];
   int            k [2];
   logic          m_fill [2];
   logic [AW-1:0] m_src [2], m_dst [2], m_len [2];
   logic [DW-1:0] m_fv [2];

   task automatic chk(input string nm, input int j, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s (lat%0d): got %0h expected %0h at %0t", nm, (j == 0) ? 1 : 3, a, e, $time);
      end
   endtask

   function automatic int per_word(input int j);
      return m_fill[j] ? 1 : ((j == 0) ? 3 : 5);
   endfunction

   function automatic int last_k(input int j);
      return (m_len[j] == '0) ? 1 : int'(m_len[j]) * per_word(j) + 1;
   endfunction

   task automatic exp_at(input int j, output logic eb, ed, el, ca, co,
                         output logic [AW-1:0] ea, output logic [DW-1:0] eo);
      int p, w, ph;
      eb = 0; ed = 0; el = 0; ca = 1; co = 1; ea = '0; eo = '0;
      if (act[j]) begin
         p = per_word(j);
         if (k[j] >= last_k(j)) begin
            ed = 1; ca = 0; co = 0;
         end else begin
            w  = (k[j] - 1) / p;
            ph = (k[j] - 1) % p;
            eb = 1;
            if (ph == p - 1) begin
               el = 1;
               ea = m_dst[j] + AW'(w);
               eo = m_fill[j] ? m_fv[j] : gold[j][m_src[j] + AW'(w)];
            end else begin
               ea = m_src[j] + AW'(w);
               co = 0;
            end
         end
      end
   endtask

   always @(posedge clk) begin : mem_and_model
      logic eb, ed, el, ca, co;
      logic [AW-1:0] ea;
      logic [DW-1:0] eo;
      for (int j = 0; j < 2; j++) begin
         if (dload[j]) ram[j][daddr[j]] <= dout[j];
         if (pl_we) begin
            ram[j][pl_a]  <= pl_d;
            gold[j][pl_a] <= pl_d;
         end
         exp_at(j, eb, ed, el, ca, co, ea, eo);
         if (act[j] === 1'b1 && el) gold[j][ea] <= eo;
         if (reset) act[j] <= 1'b0;
         else if (act[j]) begin
            if (k[j] >= last_k(j)) act[j] <= 1'b0;
            else                   k[j]   <= k[j] + 1;
         end else if (st) begin
            act[j] <= 1'b1;  k[j] <= 1;  m_fill[j] <= fl;
            m_src[j] <= sr;  m_dst[j] <= ds;  m_len[j] <= ln;  m_fv[j] <= fv;
         end
      end
      a1    <= daddr[0];
      a3[0] <= daddr[1];
      a3[1] <= a3[0];
      a3[2] <= a3[1];
   end

   always @(negedge clk) begin : compare
      logic eb, ed, el, ca, co;
      logic [AW-1:0] ea;
      logic [DW-1:0] eo;
      if (chk_en) begin
         for (int j = 0; j < 2; j++) begin
            exp_at(j, eb, ed, el, ca, co, ea, eo);
            chk("busy", j, dbusy[j], eb);
            chk("done", j, ddone[j], ed);
            chk("mem_load", j, dload[j], el);
            if (ca) chk("mem_address", j, daddr[j], ea);
            if (co) chk("mem_out", j, dout[j], eo);
         end
      end
   end

   int bc [2], lc [2], dc [2], dk [2];

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pl_a = a; pl_d = d; pl_we = 1'b1;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic run_op(input logic f, input logic [AW-1:0] s, d, l, input logic [DW-1:0] v,
                         input int ign, input int rst_at);
      int it;
      for (int j = 0; j < 2; j++) begin bc[j] = 0; lc[j] = 0; dc[j] = 0; dk[j] = 0; end
      st = 1'b1; fl = f; sr = s; ds = d; ln = l; fv = v;
      @(posedge clk); #1;
      st = 1'b0; fl = 1'($urandom); sr = AW'($urandom); ds = AW'($urandom);
      ln = AW'($urandom); fv = DW'($urandom);
      for (it = 1; it <= 400; it++) begin
         @(negedge clk);
         for (int j = 0; j < 2; j++) begin
            if (dbusy[j]) bc[j]++;
            if (dload[j]) lc[j]++;
            if (ddone[j]) begin dc[j]++; dk[j] = it; end
         end
         if (it == ign) begin
            st = 1'b1; fl = 1'($urandom); sr = AW'($urandom); ds = AW'($urandom);
            ln = AW'($urandom); fv = DW'($urandom);
         end
         if (it == ign + 1) st = 1'b0;
         if (it == rst_at) reset = 1'b1;
         if (it == rst_at + 1) reset = 1'b0;
         if (!act[0] && !act[1] && !st && !reset) break;
      end
      chk("op_end", 0, it <= 400, 1);
   endtask

   initial begin
      logic [DW-1:0] keep0, keep1;
      int l, mm;
      repeat (2) @(negedge clk);
      for (int a = 0; a < N; a++) preload(AW'(a), DW'($urandom));
      reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy", 0, dbusy[0], 0);
      chk("rst_addr", 1, daddr[1], 0);
      chk("rst_load", 0, dload[0], 0);

      // copy 0x010 -> 0x100, a start pulse mid-operation must be ignored
      for (int i = 0; i < 4; i++) preload(AW'('h010 + i), DW'('hA000 + i));
      run_op(1'b0, 'h010, 'h100, 4, '0, 2, -5);
      chk("copy_busy_cycles", 0, bc[0], 12);
      chk("copy_busy_cycles", 1, bc[1], 20);
      chk("copy_done_cycle", 0, dk[0], 13);
      chk("copy_done_cycle", 1, dk[1], 21);
      for (int j = 0; j < 2; j++) begin
         chk("copy_load_cycles", j, lc[j], 4);
         chk("copy_done_count", j, dc[j], 1);
         for (int i = 0; i < 4; i++) chk("copy_word", j, ram[j][AW'('h100 + i)], 'hA000 + i);
      end

      keep0 = ram[0]['h205];
      run_op(1'b1, 'h000, 'h200, 5, 'hBEEF, -5, -5);
      chk("fill_load_cycles", 0, lc[0], 5);
      chk("fill_busy_cycles", 1, bc[1], 5);
      chk("fill_done_cycle", 0, dk[0], 6);
      chk("fill_first", 0, ram[0]['h200], 'hBEEF);
      chk("fill_last", 0, ram[0]['h204], 'hBEEF);
      chk("fill_beyond", 0, ram[0]['h205], keep0);

      run_op(1'b0, 'h123, 'h456, 0, '0, -5, -5);
      chk("len0_busy", 0, bc[0], 0);
      chk("len0_load", 1, lc[1], 0);
      chk("len0_done_count", 0, dc[0], 1);
      chk("len0_done_cycle", 1, dk[1], 1);

      keep0 = ram[0]['hFFD];
      run_op(1'b1, '0, 'hFFE, 3, 'h1234, -5, -5);
      chk("wrap_ffe", 0, ram[0]['hFFE], 'h1234);
      chk("wrap_fff", 0, ram[0]['hFFF], 'h1234);
      chk("wrap_000", 0, ram[0]['h000], 'h1234);
      chk("wrap_before", 0, ram[0]['hFFD], keep0);

      preload('h020, 'h0007); preload('h021, 'h0001); preload('h022, 'h0002);
      preload('h023, 'h0003); preload('h024, 'h0099);
      run_op(1'b0, 'h020, 'h021, 3, '0, -5, -5);
      for (int j = 0; j < 2; j++) begin
         for (int i = 1; i < 4; i++) chk("overlap_word", j, ram[j][AW'('h020 + i)], 'h0007);
         chk("overlap_beyond", j, ram[j]['h024], 'h0099);
      end

      for (int i = 0; i < 4; i++) preload(AW'('h300 + i), DW'('h5550 + i));
      keep0 = ram[0]['h401];
      keep1 = ram[1]['h401];
      run_op(1'b0, 'h300, 'h400, 4, '0, -5, 5);
      repeat (3) @(negedge clk);
      for (int j = 0; j < 2; j++) begin
         chk("abort_done_count", j, dc[j], 0);
         chk("abort_load_cycles", j, lc[j], 1);
         chk("abort_word0", j, ram[j]['h400], 'h5550);
      end
      chk("abort_word1", 0, ram[0]['h401], keep0);
      chk("abort_word1", 1, ram[1]['h401], keep1);

      repeat (25) begin
         l = int'($urandom_range(0, 9));
         run_op(1'($urandom), AW'($urandom), AW'($urandom), AW'(l), DW'($urandom),
                (l != 0 && ($urandom % 2) == 1) ? 2 : -5, -5);
      end

      for (int j = 0; j < 2; j++) begin
         mm = 0;
         for (int a = 0; a < N; a++) if (ram[j][a] !== gold[j][a]) mm++;
         chk("mem_image_mismatches", j, mm, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
